// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle RV32I control FSM with imem/dmem handshakes and a bus timeout.
//               Optional illegal-opcode trap state: MULTICYCLE_TRAP_ILLEGAL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_branch_taken,
  output logic       o_imem_req,
  input  logic       i_imem_ack,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  input  logic       i_dmem_ack,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  output logic       o_alu_a_sel,
  output logic       o_alu_b_sel,
  output logic [1:0] o_wb_sel,
  output logic       o_reg_we,
  output logic       o_retire,
  output logic       o_bus_err,
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
  output logic       o_illegal_instr,
`endif
  output logic [2:0] o_state
);

  localparam logic [2:0] C_ST_IDLE   = 3'd0;
  localparam logic [2:0] C_ST_FETCH  = 3'd1;
  localparam logic [2:0] C_ST_DECODE = 3'd2;
  localparam logic [2:0] C_ST_EXEC   = 3'd3;
  localparam logic [2:0] C_ST_MEM    = 3'd4;
  localparam logic [2:0] C_ST_WB     = 3'd5;
  localparam logic [2:0] C_ST_TRAP   = 3'd6;

  localparam logic [3:0] C_CL_OP     = 4'd0;
  localparam logic [3:0] C_CL_OPIMM  = 4'd1;
  localparam logic [3:0] C_CL_LOAD   = 4'd2;
  localparam logic [3:0] C_CL_STORE  = 4'd3;
  localparam logic [3:0] C_CL_BRANCH = 4'd4;
  localparam logic [3:0] C_CL_JAL    = 4'd5;
  localparam logic [3:0] C_CL_JALR   = 4'd6;
  localparam logic [3:0] C_CL_LUI    = 4'd7;
  localparam logic [3:0] C_CL_AUIPC  = 4'd8;
  localparam logic [3:0] C_CL_NOP    = 4'd9;
  localparam logic [3:0] C_CL_ILL    = 4'd10;

  localparam int             C_CW     = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [C_CW-1:0] C_LAST  = C_CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic           C_TO_EN  = (TIMEOUT_CYC > 0);

  logic [2:0]      r_state;
  logic [2:0]      w_next;
  logic [3:0]      r_cls;
  logic [3:0]      w_dec_cls;
  logic [C_CW-1:0] r_cnt;
  logic            w_req_wait;
  logic            w_expire;

  always_comb begin
    case (i_opcode)
      7'b0110011: w_dec_cls = C_CL_OP;
      7'b0010011: w_dec_cls = C_CL_OPIMM;
      7'b0000011: w_dec_cls = C_CL_LOAD;
      7'b0100011: w_dec_cls = C_CL_STORE;
      7'b1100011: w_dec_cls = C_CL_BRANCH;
      7'b1101111: w_dec_cls = C_CL_JAL;
      7'b1100111: w_dec_cls = C_CL_JALR;
      7'b0110111: w_dec_cls = C_CL_LUI;
      7'b0010111: w_dec_cls = C_CL_AUIPC;
      7'b0001111,
      7'b1110011: w_dec_cls = C_CL_NOP;
      default:    w_dec_cls = C_CL_ILL;
    endcase
  end

  // The last unacked request cycle of a window expires; an ack in that cycle still wins.
  assign w_req_wait = ((r_state == C_ST_FETCH) && !i_imem_ack) ||
                      ((r_state == C_ST_MEM)   && !i_dmem_ack);
  assign w_expire   = C_TO_EN && w_req_wait && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_ST_IDLE;
      r_cls   <= C_CL_OP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == C_ST_DECODE) r_cls <= w_dec_cls;
      if (w_req_wait && !w_expire) r_cnt <= r_cnt + 1'b1;
      else                         r_cnt <= '0;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_imem_req  = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = 2'b00;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_wb_sel    = 2'b00;
    o_reg_we    = 1'b0;
    o_retire    = 1'b0;
    o_bus_err   = 1'b0;
    if ((r_state == C_ST_EXEC) || (r_state == C_ST_MEM) || (r_state == C_ST_WB)) begin
      o_alu_a_sel = (r_cls == C_CL_AUIPC);
      o_alu_b_sel = (r_cls == C_CL_OPIMM) || (r_cls == C_CL_LOAD) || (r_cls == C_CL_STORE) ||
                    (r_cls == C_CL_JALR)  || (r_cls == C_CL_AUIPC);
      case (r_cls)
        C_CL_LOAD:           o_wb_sel = 2'b01;
        C_CL_JAL, C_CL_JALR: o_wb_sel = 2'b10;
        C_CL_LUI:            o_wb_sel = 2'b11;
        default:             o_wb_sel = 2'b00;
      endcase
    end
    case (r_state)
      C_ST_IDLE: w_next = C_ST_FETCH;
      C_ST_FETCH: begin
        o_imem_req = 1'b1;
        if (i_imem_ack) begin
          o_ir_we = 1'b1;
          w_next  = C_ST_DECODE;
        end else if (w_expire) begin
          o_bus_err = 1'b1;
        end
      end
      C_ST_DECODE: begin
        w_next = C_ST_EXEC;
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
        if (w_dec_cls == C_CL_ILL) w_next = C_ST_TRAP;
`endif
      end
      C_ST_EXEC: begin
        case (r_cls)
          C_CL_LOAD, C_CL_STORE: w_next = C_ST_MEM;
          C_CL_BRANCH: begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_branch_taken ? 2'b01 : 2'b00;
            o_retire = 1'b1;
            w_next   = C_ST_FETCH;
          end
          C_CL_NOP: begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            w_next   = C_ST_FETCH;
          end
          // Illegal opcodes are skipped here so pc_we never fires in DECODE.
          C_CL_ILL: begin
            o_pc_we = 1'b1;
            w_next  = C_ST_FETCH;
          end
          default: w_next = C_ST_WB;
        endcase
      end
      C_ST_MEM: begin
        o_dmem_req = 1'b1;
        o_dmem_we  = (r_cls == C_CL_STORE);
        if (i_dmem_ack) begin
          if (r_cls == C_CL_STORE) begin
            o_pc_we  = 1'b1;
            o_retire = 1'b1;
            w_next   = C_ST_FETCH;
          end else begin
            w_next = C_ST_WB;
          end
        end else if (w_expire) begin
          o_bus_err = 1'b1;
          o_pc_we   = 1'b1;
          w_next    = C_ST_FETCH;
        end
      end
      C_ST_WB: begin
        o_reg_we = 1'b1;
        o_pc_we  = 1'b1;
        o_retire = 1'b1;
        o_pc_sel = (r_cls == C_CL_JAL) ? 2'b01 : (r_cls == C_CL_JALR) ? 2'b10 : 2'b00;
        w_next   = C_ST_FETCH;
      end
      C_ST_TRAP: w_next = C_ST_TRAP;
      default:   w_next = C_ST_IDLE;
    endcase
  end

`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
  assign o_illegal_instr = (r_state == C_ST_TRAP);
`endif
  assign o_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Randomized bench for multicycle_ctrl against a per-instruction trace model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam int K_OP = 0, K_OPIMM = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4, K_JAL = 5;
  localparam int K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_NOP = 9, K_ILL = 10;

  typedef struct packed {
    logic [2:0] st;
    logic       ireq, dreq, dwe, irwe, pcwe;
    logic [1:0] pcsel;
    logic       aa, ab;
    logic [1:0] wb;
    logic       rwe, ret, berr, ill;
  } exp_t;

  typedef struct {
    logic ia, da, tk;
    exp_t e;
  } cyc_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] i_opcode = 7'd0;
  logic       i_branch_taken = 1'b0, i_imem_ack = 1'b0, i_dmem_ack = 1'b0;
  logic       o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we;
  logic [1:0] o_pc_sel, o_wb_sel;
  logic       o_alu_a_sel, o_alu_b_sel, o_reg_we, o_retire, o_bus_err;
  logic [2:0] o_state;
  logic       w_ill;

  cyc_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT_CYC(TO)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(i_opcode), .i_branch_taken(i_branch_taken),
    .o_imem_req(o_imem_req), .i_imem_ack(i_imem_ack), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .i_dmem_ack(i_dmem_ack), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
    .o_pc_sel(o_pc_sel), .o_alu_a_sel(o_alu_a_sel), .o_alu_b_sel(o_alu_b_sel),
    .o_wb_sel(o_wb_sel), .o_reg_we(o_reg_we), .o_retire(o_retire), .o_bus_err(o_bus_err),
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
    .o_illegal_instr(w_ill),
`endif
    .o_state(o_state)
  );
`ifndef MULTICYCLE_TRAP_ILLEGAL_EN
  assign w_ill = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t got_vec();
    return {o_state, o_imem_req, o_dmem_req, o_dmem_we, o_ir_we, o_pc_we, o_pc_sel,
            o_alu_a_sel, o_alu_b_sel, o_wb_sel, o_reg_we, o_retire, o_bus_err, w_ill};
  endfunction

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_OP;
      7'b0010011: return K_OPIMM;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BRANCH;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b0001111, 7'b1110011: return K_NOP;
      default: return K_ILL;
    endcase
  endfunction

  function automatic exp_t with_sels(input exp_t e, input int k);
    exp_t r = e;
    r.aa = (k == K_AUIPC);
    r.ab = (k == K_OPIMM) || (k == K_LOAD) || (k == K_STORE) || (k == K_JALR) || (k == K_AUIPC);
    r.wb = (k == K_LOAD) ? 2'b01 : ((k == K_JAL) || (k == K_JALR)) ? 2'b10 :
           (k == K_LUI) ? 2'b11 : 2'b00;
    return r;
  endfunction

  task automatic push(input exp_t e, input logic ia, input logic da, input logic tk);
    cyc_t c;
    c.e = e; c.ia = ia; c.da = da; c.tk = tk;
    q.push_back(c);
  endtask

  // Expected trace of one instruction: fetch waits fw cycles, memory waits mw cycles.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic tk);
    int   k = cls_of(op);
    exp_t e;
    i_opcode = op;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.st = 3'd1; e.ireq = 1'b1;
      if (i == fw) e.irwe = 1'b1;
      else if ((i + 1) % TO == 0) e.berr = 1'b1;
      push(e, (i == fw), 1'($urandom), 1'($urandom));
    end
    e = '0; e.st = 3'd2;
    push(e, 1'($urandom), 1'($urandom), 1'($urandom));
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
    if (k == K_ILL) begin
      for (int i = 0; i < 10; i++) begin
        e = '0; e.st = 3'd6; e.ill = 1'b1;
        push(e, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      return;
    end
`endif
    e = with_sels('0, k); e.st = 3'd3;
    if (k == K_BRANCH) begin e.pcwe = 1'b1; e.ret = 1'b1; e.pcsel = {1'b0, tk}; end
    if (k == K_NOP) begin e.pcwe = 1'b1; e.ret = 1'b1; end
    if (k == K_ILL) e.pcwe = 1'b1;
    push(e, 1'($urandom), 1'($urandom), tk);
    if ((k == K_BRANCH) || (k == K_NOP) || (k == K_ILL)) return;
    if ((k == K_LOAD) || (k == K_STORE)) begin
      for (int i = 0; i < ((mw < TO) ? mw + 1 : TO); i++) begin
        e = with_sels('0, k); e.st = 3'd4; e.dreq = 1'b1; e.dwe = (k == K_STORE);
        if (i == mw) begin
          if (k == K_STORE) begin e.pcwe = 1'b1; e.ret = 1'b1; end
        end else if (i == TO - 1) begin
          e.berr = 1'b1; e.pcwe = 1'b1;
        end
        push(e, 1'($urandom), (i == mw), 1'($urandom));
      end
      if ((k == K_STORE) || (mw >= TO)) return;
    end
    e = with_sels('0, k); e.st = 3'd5; e.rwe = 1'b1; e.pcwe = 1'b1; e.ret = 1'b1;
    e.pcsel = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
    push(e, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic run_n(input int n);
    cyc_t c;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      c = q.pop_front();
      i_imem_ack = c.ia; i_dmem_ack = c.da; i_branch_taken = c.tk;
      #2;
      check_val($sformatf("state%0d_outputs", c.e.st), 32'(got_vec()), 32'(c.e));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check_val("reset_outputs", 32'(got_vec()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push('0, 1'b1, 1'b1, 1'b1);
    run_n(1);
  endtask

  logic [6:0] op_tab [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111,
                              7'b1110011, 7'b0000000};

  initial begin
    logic [6:0] op;
    do_reset();
    gen_instr(7'b0010011, 0, 0, 1'b0); run_n(q.size());   // ADDI
    gen_instr(7'b0000011, 0, 3, 1'b0); run_n(q.size());   // LW, ack in expiry cycle
    gen_instr(7'b1100011, 0, 0, 1'b1); run_n(q.size());   // BEQ taken
    gen_instr(7'b1100011, 0, 0, 1'b0); run_n(q.size());   // BEQ not taken
    gen_instr(7'b0010011, 7, 0, 1'b0); run_n(q.size());   // fetch timeout then late ack
    gen_instr(7'b0100011, 0, 0, 1'b0); run_n(q.size());   // SW zero-wait
    gen_instr(7'b0000011, 1, 6, 1'b0); run_n(q.size());   // LW memory timeout
`ifndef MULTICYCLE_TRAP_ILLEGAL_EN
    gen_instr(7'b0000000, 0, 0, 1'b0); run_n(q.size());   // silent skip
`endif
    for (int n = 0; n < 300; n++) begin
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : op_tab[$urandom_range(0, 11)];
`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
      if (cls_of(op) == K_ILL) op = 7'b0110011;
`endif
      gen_instr(op, $urandom_range(0, 9), $urandom_range(0, 5), 1'($urandom));
      run_n(q.size());
    end

    // Asynchronous reset in the middle of a stalled load.
    gen_instr(7'b0000011, 0, 9, 1'b0);
    run_n(4);
    q.delete();
    i_dmem_ack = 1'b0;
    #2;
    check_val("midmem_dreq_before", 32'(o_dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("midmem_dreq_after_rst", 32'(o_dmem_req), 32'd0);
    check_val("midmem_state_after_rst", 32'(o_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_val("release_idle", 32'(o_state), 32'd0);
    @(negedge clk);
    i_imem_ack = 1'b0;
    #2;
    check_val("release_fetch", 32'(o_state), 32'd1);
    check_val("release_fetch_req", 32'(o_imem_req), 32'd1);

`ifdef MULTICYCLE_TRAP_ILLEGAL_EN
    do_reset();
    gen_instr(7'b0000000, 0, 0, 1'b0); run_n(q.size());
`endif
    do_reset();
    gen_instr(7'b0110111, 0, 0, 1'b0); run_n(q.size());   // LUI after final reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
